muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit beside the execute-stage ALU. Implements MIPS MULT, MULTU, DIV, DIVU with architectural HI/LO registers, plus MTHI/MTLO writes.
- Sequences a radix-2 shift-add / restoring-divide datapath over B iterations.
- Raises a stall toward the pipeline when an instruction needs HI/LO, or needs the unit, while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_unit_sign.sv | 13 +
 rtl/muldiv_unit.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit and the control unit that drives op.
// Op codes, FSM state encoding and the default operand width.
package muldiv_pkg;

    localparam int MULDIV_B = 32;

    localparam logic [1:0] MULDIV_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_sign.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for sign correction of the final product, quotient and remainder.
module muldiv_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg_en,
    output logic [W-1:0] out
);

    assign out = neg_en ? (~in + W'(1)) : in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier; divide stays iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int B  = MULDIV_B,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [B-1:0] op1,
    input  logic [B-1:0] op2,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [B-1:0] wdata,
    input  logic         rd_req,
    output logic [B-1:0] hi,
    output logic [B-1:0] lo,
    output logic         busy,
    output logic         done,
    output logic         stall
);

    muldiv_state_e state_q, state_d;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic           rsign_q, rsign_d;
    logic           remsign_q, remsign_d;
    logic           dz_q, dz_d;
    logic [2*B-1:0] acc_q, acc_d;
    logic [B-1:0]   opb_q, opb_d;
    logic [B-1:0]   hi_q, hi_d;
    logic [B-1:0]   lo_q, lo_d;
    logic           done_q, done_d;

    logic           sgn_in;
    logic [B-1:0]   abs1, abs2;

    assign sgn_in = op_is_signed(op);

    muldiv_sign #(.W(B)) u_abs1 (
        .in     (op1),
        .neg_en (sgn_in & op1[B-1]),
        .out    (abs1)
    );

    muldiv_sign #(.W(B)) u_abs2 (
        .in     (op2),
        .neg_en (sgn_in & op2[B-1]),
        .out    (abs2)
    );

    // Multiply: acc = {partial, multiplier}; add into upper half, shift right.
    logic [B:0]     mul_sum;
    logic [2*B-1:0] mul_step;

    assign mul_sum  = {1'b0, acc_q[2*B-1:B]}
                    + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {mul_sum, acc_q[B-1:1]};

    // Divide: acc = {rem, quot}; the shifted remainder needs one extra bit.
    logic [B:0]     rem_sh;
    logic [B:0]     rem_sub;
    logic           div_ok;
    logic [2*B-1:0] div_step;

    assign rem_sh   = {acc_q[2*B-1:B], acc_q[B-1]};
    assign rem_sub  = rem_sh - {1'b0, opb_q};
    assign div_ok   = ~rem_sub[B];
    assign div_step = div_ok
                    ? {rem_sub[B-1:0], acc_q[B-2:0], 1'b1}
                    : {rem_sh[B-1:0],  acc_q[B-2:0], 1'b0};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*B-1:0] fast_prod;

    assign fast_prod = {{B{1'b0}}, acc_q[B-1:0]}
                     * {{B{1'b0}}, opb_q};
`endif

    logic           fix_sgn;
    logic [2*B-1:0] prod_fix;
    logic [B-1:0]   quot_fix;
    logic [B-1:0]   rem_fix;

    assign fix_sgn = op_is_signed(op_q);

    muldiv_sign #(.W(2*B)) u_prod (
        .in     (acc_q),
        .neg_en (fix_sgn & rsign_q),
        .out    (prod_fix)
    );

    // A zero divisor leaves the quotient at all ones; negating the
    // remainder magnitude by the dividend sign restores the raw dividend.
    muldiv_sign #(.W(B)) u_quot (
        .in     (acc_q[B-1:0]),
        .neg_en (fix_sgn & rsign_q & ~dz_q),
        .out    (quot_fix)
    );

    muldiv_sign #(.W(B)) u_rem (
        .in     (acc_q[2*B-1:B]),
        .neg_en (fix_sgn & remsign_q),
        .out    (rem_fix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rsign_d   = rsign_q;
        remsign_d = remsign_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    rsign_d   = op1[B-1] ^ op2[B-1];
                    remsign_d = op1[B-1];
                    dz_d      = (op2 == '0);
                    cnt_d     = CW'(B - 1);
                    state_d   = ST_CALC;
                    if (op_is_div(op)) begin
                        acc_d = {{B{1'b0}}, abs1};
                        opb_d = abs2;
                    end else begin
                        acc_d = {{B{1'b0}}, abs2};
                        opb_d = abs1;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            ST_CALC: begin
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (op_is_div(op_q)) begin
                    acc_d = div_step;
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                    acc_d   = fast_prod;
                    cnt_d   = '0;
                    state_d = ST_FIX;
`else
                    acc_d = mul_step;
`endif
                end
            end
            ST_FIX: begin
                if (op_is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*B-1:B];
                    lo_d = prod_fix[B-1:0];
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rsign_q   <= 1'b0;
            remsign_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rsign_q   <= rsign_d;
            remsign_q <= remsign_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign stall = busy & (start | rd_req | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (default iterative build, B=32).
// Results and cycle counts are checked against hand-computed values.
module tb_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        rd_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int tests;
    int fails;
    int lat;
    int bcnt;
    int scnt;
    logic stall_at_done;

    muldiv_unit #(.B(32), .CW(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .op1     (op1),
        .op2     (op2),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .rd_req  (rd_req),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns edges from start to done.
    task automatic run_op(input logic [1:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output int l,
                          output int bc);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        bc = busy ? 1 : 0;
        l  = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                l = k;
                break;
            end
            if (busy) bc++;
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        op1     = '0;
        op2     = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        rd_req  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi",    hi,           32'h0);
        chk("rst_lo",    lo,           32'h0);
        chk("rst_busy",  {31'b0, busy},  32'h0);
        chk("rst_done",  {31'b0, done},  32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // MULT -3 * 7
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        chk("mult_lat",  32'(lat),  32'd33);
        chk("mult_busy", 32'(bcnt), 32'd33);
        chk("mult_hi",   hi,        32'hFFFF_FFFF);
        chk("mult_lo",   lo,        32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        chk("mult_done_pulse", {31'b0, done}, 32'h0);

        // MULTU max * max
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("multu_lat", 32'(lat), 32'd33);
        chk("multu_hi",  hi,       32'hFFFF_FFFE);
        chk("multu_lo",  lo,       32'h0000_0001);

        // DIV -7 / 2
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        chk("div_lat", 32'(lat), 32'd33);
        chk("div_hi",  hi,       32'hFFFF_FFFF);
        chk("div_lo",  lo,       32'hFFFF_FFFD);

        // DIVU 7 / 0
        run_op(2'b11, 32'd7, 32'd0, lat, bcnt);
        chk("divu0_lat", 32'(lat), 32'd33);
        chk("divu0_hi",  hi,       32'h0000_0007);
        chk("divu0_lo",  lo,       32'hFFFF_FFFF);

        // DIV most-negative / -1 wraps
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("divwrap_hi", hi, 32'h0000_0000);
        chk("divwrap_lo", lo, 32'h8000_0000);

        // DIV -7 / 0: HI keeps raw dividend, no quotient negate
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, lat, bcnt);
        chk("div0s_hi", hi, 32'hFFFF_FFF9);
        chk("div0s_lo", lo, 32'hFFFF_FFFF);

        // MULT 5*6 with MFHI + MTHI arriving mid-flight
        start = 1'b1;
        op    = 2'b00;
        op1   = 32'd5;
        op2   = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        scnt  = 0;
        lat   = -1;
        stall_at_done = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                stall_at_done = stall;
                break;
            end
            if (k == 5) begin
                rd_req = 1'b1;
                hi_we  = 1'b1;
                wdata  = 32'hDEAD_BEEF;
            end
            if (k == 6) chk("busy_hiwe_hi", hi, 32'hFFFF_FFF9);
            if (k >= 5) begin
                #1;
                if (stall) scnt++;
            end
        end
        rd_req = 1'b0;
        hi_we  = 1'b0;
        chk("stall_lat",     32'(lat),  32'd33);
        chk("stall_cycles",  32'(scnt), 32'd28);
        chk("stall_at_done", {31'b0, stall_at_done}, 32'h0);
        chk("stall_mult_hi", hi, 32'h0);
        chk("stall_mult_lo", lo, 32'h0000_001E);

        // MTHI then MTLO in IDLE
        @(posedge clk);
        #1;
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        #1;
        chk("mthi_stall", {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h0000_1234);
        lo_we = 1'b1;
        wdata = 32'h0000_5678;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_5678);
        chk("mtlo_hi", hi, 32'h0000_1234);

        // Reset during a DIV
        start = 1'b1;
        op    = 2'b10;
        op1   = 32'd100;
        op2   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'b0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midrst_hi",   hi,             32'h0);
        chk("midrst_lo",   lo,             32'h0);
        chk("midrst_busy", {31'b0, busy},  32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(2'b00, 32'd2, 32'd3, lat, bcnt);
        chk("postrst_lat", 32'(lat), 32'd33);
        chk("postrst_hi",  hi,       32'h0);
        chk("postrst_lo",  lo,       32'h0000_0006);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
